cache_burst_engine: RTL and testbench
=====================================

# cache_burst_engine

Parametrised line-transfer engine between the set-associative cache controller and the SDRAM controller. It moves whole cache lines as bursts of narrow memory beats, in three modes:
- fill (RAM to cache);
- write-back (cache to RAM);
- combined evict-then-fill, which writes the victim line back and then fetches the new line without returning to idle.

It generalises the fixed 4-word/16-bit/8-beat line format to any line length and memory width.

## Interface
Parameters:
- LINE_WORDS, 4: 32-bit words per cache line; power of two, 2..16.
- MEM_W, 16: SDRAM beat width; 16 or 32.
- ADDR_W, 24: SDRAM word-address width.
- Derived: BEATS = LINE_WORDS*32/MEM_W; BW = log2(BEATS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request strobe.
- req_ready  out  1  engine idle, able to accept a request.
- req_mode  in  2  00 none (illegal), 01 fill, 10 write-back, 11 write-back then fill.
- req_wb_addr  in  ADDR_W  write-back base address (SDRAM words).
- req_fill_addr  in  ADDR_W  fill base address (SDRAM words).
- line_wdata  in  LINE_WORDS*32  victim line; word 0 in the MSBs.
- line_rdata  out  LINE_WORDS*32  filled line; same layout.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: illegal mode.
- mem_addr  out  ADDR_W  beat address.
- mem_wr  out  1  write beat valid.
- mem_wdata  out  MEM_W  write beat data.
- mem_rd  out  1  read-burst command, held until accepted.
- mem_ready  in  1  accepts the current write beat or read command.
- mem_rdata  in  MEM_W  read beat data.
- mem_rvalid  in  1  read beat valid.

## Operation
- States: IDLE, WR_BURST, RD_CMD, RD_BURST, DONE.
- Request acceptance:
  - A request is accepted on a cycle with req_valid && req_ready.
  - At acceptance the engine samples req_mode, both addresses and line_wdata.
  - The low BW bits of each address are forced to 0, so every burst is line-aligned.
- Beat order:
  - Beat k maps to line bits [LINE_WORDS*32-1-k*MEM_W -: MEM_W].
  - Word 0 goes first, and the high halfword of each word goes before the low halfword.
- IDLE transitions: mode 10 or 11 goes to WR_BURST; mode 01 goes to RD_CMD; mode 00 goes to DONE with err=1 and produces no memory activity.
- WR_BURST:
  - mem_wr=1, mem_addr = wb_base + beat, mem_wdata = beat k.
  - The beat advances on mem_ready.
  - After the last beat is accepted, the next state is RD_CMD if mode is 11, otherwise DONE.
- RD_CMD:
  - mem_rd=1, mem_addr = fill_base, held until mem_ready.
  - The state then moves to RD_BURST.
- RD_BURST:
  - Each mem_rvalid captures mem_rdata into beat slot k of line_rdata.
  - After beat BEATS-1 is captured, the state moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- line_rdata holds its value from the DONE of a fill until the next fill's first captured beat.
- Address arithmetic: base + beat is modulo 2^ADDR_W, and wraps silently at the top of memory.
- mem_rvalid outside RD_BURST is ignored. mem_ready outside WR_BURST and RD_CMD is ignored.
- req_valid while busy is not accepted; the requester holds it.

## Timing
- Reset values: req_ready=0, done=0, err=0, mem_wr=0, mem_rd=0, mem_addr=0, mem_wdata=0, line_rdata=0. The state is IDLE.
- req_ready is registered. It rises on the first clk edge with rst_n high, and falls on the edge after acceptance.
- Latency, counted from the acceptance edge to the done pulse, with memory never stalling and mem_rvalid arriving back-to-back the cycle after the command:
  - write-back: BEATS+1 cycles;
  - fill: BEATS+2 cycles;
  - write-back then fill: 2*BEATS+2 cycles;
  - illegal mode: 1 cycle.
- After DONE, req_ready is high again in the following cycle; there is no back-to-back acceptance in the DONE cycle.
- Reset asserted mid-operation:
  - all outputs go to their reset values immediately (asynchronous);
  - the burst is abandoned and no done is produced;
  - the SDRAM controller must drop its partial burst on reset as well.
- All outputs are registered; there is no combinational path from mem_* inputs to mem_* outputs.

## Structure
- Add to mem_defines:
  - xfer_mode_t enum {XFER_NONE, XFER_FILL, XFER_WB, XFER_WB_FILL};
  - xfer_state_t enum of the five states;
  - a localparam function that computes BEATS from LINE_WORDS and MEM_W.
- Sub-module line_beat_shifter serialises line_wdata into MEM_W beats and deserialises mem_rdata into line_rdata. It is a parametrised shift register with load, shift and capture.
- The engine itself contains the FSM, a BW-bit beat counter and the address adders.

## Test plan
- Write-back (LINE_WORDS=4, MEM_W=16), mem_ready always 1:
  - stimulus: wb_addr=0x000013, line_wdata=0x11112222_33334444_55556666_77778888;
  - required: 8 writes to addresses 0x10..0x17 with data 1111, 2222, …, 8888, then done 9 cycles after acceptance.
- Fill with mem_ready low for 3 cycles on the command and mem_rvalid gapped every other cycle:
  - required: mem_rd is held 4 cycles, 8 beats are captured in order, line_rdata matches, done fires once with err=0.
- Mode 11 with wb_addr=0xFFFFF8 and fill_addr=0x000040:
  - required: writes to 0xFFFFF8..0xFFFFFF, then a read command at 0x000040, with no idle cycle between the last write acceptance and mem_rd.
- Mode 00:
  - required: done=1 and err=1 on the cycle after acceptance; mem_wr and mem_rd never assert.
- rst_n pulled low after write beat 3:
  - required: mem_wr drops asynchronously and done never pulses; after release, req_ready rises on the first edge and a fresh fill completes correctly.
- LINE_WORDS=8, MEM_W=32:
  - required: 8 beats with one 32-bit word per beat; stray mem_rvalid pulses injected while in IDLE leave line_rdata unchanged.

Source files
------------

// File: rtl/cache_burst_engine_pkg.sv
// Shared types for the cache line burst engine: transfer modes, FSM states and
// the beats-per-line helper.
package cache_burst_engine_pkg;

   typedef enum logic [1:0] {
      XFER_NONE    = 2'b00,
      XFER_FILL    = 2'b01,
      XFER_WB      = 2'b10,
      XFER_WB_FILL = 2'b11
   } xfer_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_BURST,
      ST_RD_CMD,
      ST_RD_BURST,
      ST_DONE
   } xfer_state_t;

   function automatic int calc_beats(input int line_words, input int mem_w);
      return line_words * 32 / mem_w;
   endfunction

endpackage

// File: rtl/cache_burst_engine_line_beat_shifter.sv
// Serialises a cache line into memory beats (MSB beat first) and gathers
// incoming read beats back into a line in the same order.
module cache_burst_engine_line_beat_shifter #(
   parameter int LINE_W = 128,
   parameter int MEM_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [LINE_W-1:0] line_i,
   input  logic              shift_i,
   input  logic              capture_i,
   input  logic [MEM_W-1:0]  beat_i,
   output logic [MEM_W-1:0]  wdata_o,
   output logic [LINE_W-1:0] line_o
);

   logic [LINE_W-1:0] tx_q, tx_d;
   logic [LINE_W-1:0] rx_q, rx_d;

   always_comb begin
      tx_d = tx_q;
      rx_d = rx_q;
      if (load_i)
         tx_d = line_i;
      else if (shift_i)
         tx_d = {tx_q[LINE_W-MEM_W-1:0], {MEM_W{1'b0}}};
      // Shift-in leaves beat 0 in the MSBs once the whole line has arrived.
      if (capture_i)
         rx_d = {rx_q[LINE_W-MEM_W-1:0], beat_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q <= '0;
         rx_q <= '0;
      end else begin
         tx_q <= tx_d;
         rx_q <= rx_d;
      end
   end

   assign wdata_o = tx_q[LINE_W-1 -: MEM_W];
   assign line_o  = rx_q;

endmodule

// File: rtl/cache_burst_engine.sv
// Moves whole cache lines to/from SDRAM as MEM_W-wide bursts: fill, write-back,
// or write-back followed by fill. Every output is driven from a register.
module cache_burst_engine
   import cache_burst_engine_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int MEM_W      = 16,
   parameter int ADDR_W     = 24
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [1:0]                 req_mode,
   input  logic [ADDR_W-1:0]          req_wb_addr,
   input  logic [ADDR_W-1:0]          req_fill_addr,
   input  logic [LINE_WORDS*32-1:0]   line_wdata,
   output logic [LINE_WORDS*32-1:0]   line_rdata,
   output logic                       done,
   output logic                       err,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic                       mem_wr,
   output logic [MEM_W-1:0]           mem_wdata,
   output logic                       mem_rd,
   input  logic                       mem_ready,
   input  logic [MEM_W-1:0]           mem_rdata,
   input  logic                       mem_rvalid
);

   localparam int LINE_W = LINE_WORDS * 32;
   localparam int BEATS  = calc_beats(LINE_WORDS, MEM_W);
   localparam int BW     = $clog2(BEATS);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEATS - 1);
   localparam logic [BW-1:0]     LAST_BEAT  = BW'(BEATS - 1);

   xfer_state_t       state_q, state_d;
   xfer_mode_t        mode_q, mode_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [ADDR_W-1:0] wb_base_q, wb_base_d;
   logic [ADDR_W-1:0] fill_base_q, fill_base_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              req_ready_q, done_q, err_q, mem_wr_q, mem_rd_q;
   logic              load, shift, capture;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      beat_d      = beat_q;
      wb_base_d   = wb_base_q;
      fill_base_d = fill_base_q;
      load        = 1'b0;
      shift       = 1'b0;
      capture     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               mode_d      = xfer_mode_t'(req_mode);
               wb_base_d   = req_wb_addr & ALIGN_MASK;
               fill_base_d = req_fill_addr & ALIGN_MASK;
               beat_d      = '0;
               load        = req_mode[1];
               case (mode_d)
                  XFER_FILL:            state_d = ST_RD_CMD;
                  XFER_WB, XFER_WB_FILL: state_d = ST_WR_BURST;
                  default:              state_d = ST_DONE;
               endcase
            end
         end
         ST_WR_BURST: begin
            if (mem_ready) begin
               shift = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = (mode_q == XFER_WB_FILL) ? ST_RD_CMD : ST_DONE;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         ST_RD_CMD: begin
            if (mem_ready) begin
               beat_d  = '0;
               state_d = ST_RD_BURST;
            end
         end
         ST_RD_BURST: begin
            if (mem_rvalid) begin
               capture = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are precomputed from the next state so they can be registered.
      mem_addr_d = mem_addr_q;
      if (state_d == ST_WR_BURST)
         mem_addr_d = wb_base_d + ADDR_W'(beat_d);
      else if (state_d == ST_RD_CMD)
         mem_addr_d = fill_base_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= XFER_NONE;
         beat_q      <= '0;
         wb_base_q   <= '0;
         fill_base_q <= '0;
         mem_addr_q  <= '0;
         req_ready_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         beat_q      <= beat_d;
         wb_base_q   <= wb_base_d;
         fill_base_q <= fill_base_d;
         mem_addr_q  <= mem_addr_d;
         req_ready_q <= (state_d == ST_IDLE);
         done_q      <= (state_d == ST_DONE);
         err_q       <= (state_d == ST_DONE) && (mode_d == XFER_NONE);
         mem_wr_q    <= (state_d == ST_WR_BURST);
         mem_rd_q    <= (state_d == ST_RD_CMD);
      end
   end

   cache_burst_engine_line_beat_shifter #(
      .LINE_W (LINE_W),
      .MEM_W  (MEM_W)
   ) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load),
      .line_i    (line_wdata),
      .shift_i   (shift),
      .capture_i (capture),
      .beat_i    (mem_rdata),
      .wdata_o   (mem_wdata),
      .line_o    (line_rdata)
   );

   assign req_ready = req_ready_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wr    = mem_wr_q;
   assign mem_rd    = mem_rd_q;

endmodule

// File: tb/tb_cache_burst_engine.sv
// Directed bench for the line burst engine: a 4x32/16-bit instance and an
// 8x32/32-bit instance sharing clock and reset.
module tb_cache_burst_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   logic         req_valid, req_ready, done, err, mem_wr, mem_rd, mem_ready, mem_rvalid;
   logic [1:0]   req_mode;
   logic [23:0]  req_wb_addr, req_fill_addr, mem_addr;
   logic [127:0] line_wdata, line_rdata;
   logic [15:0]  mem_wdata, mem_rdata;

   logic         req_valid_b, req_ready_b, done_b, err_b, mem_wr_b, mem_rd_b, mem_ready_b, mem_rvalid_b;
   logic [1:0]   req_mode_b;
   logic [23:0]  req_wb_addr_b, req_fill_addr_b, mem_addr_b;
   logic [255:0] line_wdata_b, line_rdata_b;
   logic [31:0]  mem_wdata_b, mem_rdata_b;

   cache_burst_engine #(.LINE_WORDS(4), .MEM_W(16), .ADDR_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_mode(req_mode), .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
      .line_wdata(line_wdata), .line_rdata(line_rdata), .done(done), .err(err),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   cache_burst_engine #(.LINE_WORDS(8), .MEM_W(32), .ADDR_W(24)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_mode(req_mode_b), .req_wb_addr(req_wb_addr_b), .req_fill_addr(req_fill_addr_b),
      .line_wdata(line_wdata_b), .line_rdata(line_rdata_b), .done(done_b), .err(err_b),
      .mem_addr(mem_addr_b), .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b), .mem_rd(mem_rd_b),
      .mem_ready(mem_ready_b), .mem_rdata(mem_rdata_b), .mem_rvalid(mem_rvalid_b)
   );

   // Presents one request for a single clock; returns at the following negedge.
   task automatic accept_a(input logic [1:0] m, input logic [23:0] wa, input logic [23:0] fa,
                           input logic [127:0] ln);
      req_valid = 1'b1; req_mode = m; req_wb_addr = wa; req_fill_addr = fa; line_wdata = ln;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic accept_b(input logic [1:0] m, input logic [23:0] wa, input logic [23:0] fa,
                           input logic [255:0] ln);
      req_valid_b = 1'b1; req_mode_b = m; req_wb_addr_b = wa; req_fill_addr_b = fa; line_wdata_b = ln;
      @(posedge clk);
      @(negedge clk);
      req_valid_b = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", req_ready); end
      n_vec++; if ({done, err, mem_wr, mem_rd} !== 4'b0) begin n_err++; $display("FAIL rst_ctl got %b want 0000", {done, err, mem_wr, mem_rd}); end
      n_vec++; if (mem_addr !== 24'h0 || mem_wdata !== 16'h0) begin n_err++; $display("FAIL rst_mem got %h/%h want 0/0", mem_addr, mem_wdata); end
      n_vec++; if (line_rdata !== 128'h0) begin n_err++; $display("FAIL rst_line got %h want 0", line_rdata); end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (req_ready !== 1'b1 || req_ready_b !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b%b want 11", req_ready, req_ready_b); end
   endtask

   task automatic test_wb();
      logic [127:0] ln = 128'h11112222_33334444_55556666_77778888;
      mem_ready = 1'b1;
      accept_a(2'b10, 24'h000013, 24'h000000, ln);
      for (int k = 0; k < 8; k++) begin
         n_vec++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin n_err++; $display("FAIL wb_wr beat %0d got wr=%b rd=%b want 1/0", k, mem_wr, mem_rd); end
         n_vec++; if (mem_addr !== 24'(32'h10 + k)) begin n_err++; $display("FAIL wb_addr beat %0d got %h want %h", k, mem_addr, 24'(32'h10 + k)); end
         n_vec++; if (mem_wdata !== 16'(16'h1111 * (k + 1))) begin n_err++; $display("FAIL wb_data beat %0d got %h want %h", k, mem_wdata, 16'(16'h1111 * (k + 1))); end
         n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL wb_early_done beat %0d got %b want 0", k, done); end
         @(negedge clk);
      end
      n_vec++; if (done !== 1'b1 || err !== 1'b0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL wb_done got done=%b err=%b wr=%b want 1/0/0", done, err, mem_wr); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL wb_after got done=%b ready=%b want 0/1", done, req_ready); end
   endtask

   task automatic test_fill_stall();
      logic [127:0] ln = 128'hA1A2B1B2_C1C2D1D2_E1E2F1F2_01020304;
      mem_ready = 1'b0;
      accept_a(2'b01, 24'h000000, 24'h000125, 128'h0);
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 24'h000120 || mem_wr !== 1'b0) begin n_err++; $display("FAIL fill_cmd cycle %0d got rd=%b addr=%h wr=%b want 1/000120/0", i, mem_rd, mem_addr, mem_wr); end
         if (i == 3) mem_ready = 1'b1;
         @(negedge clk);
      end
      n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL fill_cmd_drop got %b want 0", mem_rd); end
      for (int k = 0; k < 8; k++) begin
         n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL fill_early_done beat %0d got %b want 0", k, done); end
         mem_rdata = ln[127-16*k -: 16]; mem_rvalid = 1'b1;
         @(negedge clk);
         mem_rvalid = 1'b0; mem_rdata = 16'hDEAD;
         if (k < 7) @(negedge clk);
      end
      n_vec++; if (done !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL fill_done got done=%b err=%b want 1/0", done, err); end
      n_vec++; if (line_rdata !== ln) begin n_err++; $display("FAIL fill_line got %h want %h", line_rdata, ln); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0 || line_rdata !== ln) begin n_err++; $display("FAIL fill_hold got done=%b line=%h want 0/%h", done, line_rdata, ln); end
   endtask

   task automatic test_wb_fill();
      logic [127:0] ln = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      logic [127:0] fl = 128'h13572468_9BDFACE0_0F0FF0F0_3C3CC3C3;
      mem_ready = 1'b1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL wbf_ready got %b want 1", req_ready); end
      accept_a(2'b11, 24'hFFFFF8, 24'h000040, ln);
      for (int k = 0; k < 8; k++) begin
         n_vec++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 24'(32'hFFFFF8 + k)) begin n_err++; $display("FAIL wbf_wr beat %0d got wr=%b rd=%b addr=%h want 1/0/%h", k, mem_wr, mem_rd, mem_addr, 24'(32'hFFFFF8 + k)); end
         n_vec++; if (mem_wdata !== ln[127-16*k -: 16]) begin n_err++; $display("FAIL wbf_data beat %0d got %h want %h", k, mem_wdata, ln[127-16*k -: 16]); end
         @(negedge clk);
      end
      n_vec++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 24'h000040) begin n_err++; $display("FAIL wbf_cmd got rd=%b wr=%b addr=%h want 1/0/000040", mem_rd, mem_wr, mem_addr); end
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         mem_rdata = fl[127-16*k -: 16]; mem_rvalid = 1'b1;
         @(negedge clk);
      end
      mem_rvalid = 1'b0;
      n_vec++; if (done !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL wbf_done got done=%b err=%b want 1/0", done, err); end
      n_vec++; if (line_rdata !== fl) begin n_err++; $display("FAIL wbf_line got %h want %h", line_rdata, fl); end
      @(negedge clk);
   endtask

   task automatic test_illegal();
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready got %b want 1", req_ready); end
      accept_a(2'b00, 24'h123456, 24'h654321, {128{1'b1}});
      n_vec++; if (done !== 1'b1 || err !== 1'b1) begin n_err++; $display("FAIL ill_done got done=%b err=%b want 1/1", done, err); end
      n_vec++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin n_err++; $display("FAIL ill_mem got wr=%b rd=%b want 0/0", mem_wr, mem_rd); end
      @(negedge clk);
      n_vec++; if ({done, err, mem_wr, mem_rd} !== 4'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL ill_after got %b ready=%b want 0000/1", {done, err, mem_wr, mem_rd}, req_ready); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] fl = 128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D;
      mem_ready = 1'b1;
      accept_a(2'b10, 24'h000400, 24'h000000, 128'hCAFE_BABE_0000_1111_2222_3333_4444_5555);
      repeat (4) @(negedge clk);
      n_vec++; if (mem_wr !== 1'b1 || mem_addr !== 24'h000404) begin n_err++; $display("FAIL rmid_pre got wr=%b addr=%h want 1/000404", mem_wr, mem_addr); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (mem_wr !== 1'b0 || mem_addr !== 24'h0 || mem_wdata !== 16'h0 || req_ready !== 1'b0) begin n_err++; $display("FAIL rmid_async got wr=%b addr=%h wd=%h ready=%b want 0/0/0/0", mem_wr, mem_addr, mem_wdata, req_ready); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done cycle %0d got %b want 0", i, done); end
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (req_ready !== 1'b1 || done !== 1'b0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL rmid_release got ready=%b done=%b wr=%b want 1/0/0", req_ready, done, mem_wr); end
      accept_a(2'b01, 24'h000000, 24'h00020B, 128'h0);
      n_vec++; if (mem_rd !== 1'b1 || mem_addr !== 24'h000208) begin n_err++; $display("FAIL rmid_cmd got rd=%b addr=%h want 1/000208", mem_rd, mem_addr); end
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         mem_rdata = fl[127-16*k -: 16]; mem_rvalid = 1'b1;
         @(negedge clk);
      end
      mem_rvalid = 1'b0;
      n_vec++; if (done !== 1'b1 || line_rdata !== fl) begin n_err++; $display("FAIL rmid_fill got done=%b line=%h want 1/%h", done, line_rdata, fl); end
      @(negedge clk);
   endtask

   task automatic test_wide();
      logic [255:0] wl = 256'h10000001_20000002_30000003_40000004_50000005_60000006_70000007_80000008;
      logic [255:0] fl = 256'hC0DE0000_C0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_C0DE0006_C0DE0007;
      mem_ready_b = 1'b1;
      mem_rdata_b = 32'hBADBAD00; mem_rvalid_b = 1'b1;
      repeat (3) @(negedge clk);
      mem_rvalid_b = 1'b0;
      n_vec++; if (line_rdata_b !== 256'h0) begin n_err++; $display("FAIL wide_stray_reset got %h want 0", line_rdata_b); end
      accept_b(2'b10, 24'h000207, 24'h000000, wl);
      for (int k = 0; k < 8; k++) begin
         n_vec++; if (mem_wr_b !== 1'b1 || mem_addr_b !== 24'(32'h200 + k)) begin n_err++; $display("FAIL wide_wr beat %0d got wr=%b addr=%h want 1/%h", k, mem_wr_b, mem_addr_b, 24'(32'h200 + k)); end
         n_vec++; if (mem_wdata_b !== 32'(32'h10000001 * (k + 1))) begin n_err++; $display("FAIL wide_data beat %0d got %h want %h", k, mem_wdata_b, 32'(32'h10000001 * (k + 1))); end
         @(negedge clk);
      end
      n_vec++; if (done_b !== 1'b1 || err_b !== 1'b0) begin n_err++; $display("FAIL wide_wb_done got done=%b err=%b want 1/0", done_b, err_b); end
      @(negedge clk);
      accept_b(2'b01, 24'h000000, 24'hABCDEF, 256'h0);
      n_vec++; if (mem_rd_b !== 1'b1 || mem_addr_b !== 24'hABCDE8) begin n_err++; $display("FAIL wide_cmd got rd=%b addr=%h want 1/abcde8", mem_rd_b, mem_addr_b); end
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         mem_rdata_b = 32'hC0DE0000 + 32'(k); mem_rvalid_b = 1'b1;
         @(negedge clk);
      end
      mem_rvalid_b = 1'b0;
      n_vec++; if (done_b !== 1'b1 || line_rdata_b !== fl) begin n_err++; $display("FAIL wide_fill got done=%b line=%h want 1/%h", done_b, line_rdata_b, fl); end
      @(negedge clk);
      mem_rdata_b = 32'hFFFF0000; mem_rvalid_b = 1'b1;
      repeat (3) @(negedge clk);
      mem_rvalid_b = 1'b0;
      n_vec++; if (line_rdata_b !== fl) begin n_err++; $display("FAIL wide_stray_idle got %h want %h", line_rdata_b, fl); end
   endtask

   initial begin
      req_valid = 1'b0; req_mode = 2'b00; req_wb_addr = '0; req_fill_addr = '0; line_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
      req_valid_b = 1'b0; req_mode_b = 2'b00; req_wb_addr_b = '0; req_fill_addr_b = '0; line_wdata_b = '0;
      mem_ready_b = 1'b0; mem_rdata_b = '0; mem_rvalid_b = 1'b0;
      test_reset();
      test_wb();
      test_fill_stall();
      test_wb_fill();
      test_illegal();
      test_reset_mid();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
